// File: rtl/fir_pkg.sv
// Shared FIR definitions.
//   FIR_Y_W    : width of the FIR result bus (unsigned)
//   Q_OUT_W    : default quantized sample width
//   q_sample_t : quantized sample plus its saturation flag
package fir_pkg;
  localparam int FIR_Y_W = 34;
  localparam int Q_OUT_W = 16;

  typedef struct packed {
    logic [Q_OUT_W-1:0] data;
    logic               sat;
  } q_sample_t;
endpackage

// File: rtl/sync_fifo.sv
// Flagless synchronous FIFO.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   push/din : write din this cycle (caller guarantees !full or a same-cycle pop)
//   pop      : advance head this cycle (caller guarantees !empty)
//   dout     : current head entry (combinational read)
//   full, empty, level : occupancy status
module sync_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = LW'(wr_ptr - rd_ptr);
endmodule

// File: rtl/fir_out_quantizer.sv
// Rounds and saturates the unsigned FIR result stream to OUT_W bits and
// buffers it in a small FIFO drained over valid/ready. The FIR cannot be
// stalled, so a write into a full FIFO (without a same-cycle pop) drops the
// sample and is recorded in a sticky flag and a saturating counter.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid, y         : FIR sample stream
//   out_ready           : consumer accepts the head this cycle
//   out_valid, dout,
//   dout_sat            : FIFO head (dout holds its last value when empty)
//   level               : FIFO occupancy
//   overflow, drop_cnt  : sticky drop flag, dropped-sample count (sat. 255)
module fir_out_quantizer
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_Y_W,
  parameter int OUT_W = Q_OUT_W,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  y,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_sat,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);
  // One extra bit keeps the rounding carry of an all-ones input.
  localparam logic [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic [IN_W:0] QMAX = (IN_W+1)'({OUT_W{1'b1}});

  logic [IN_W:0]    sum, r;
  logic             sat_c;
  logic [OUT_W-1:0] q_c;

  assign sum   = {1'b0, y} + RND;
  assign r     = sum >> SHIFT;
  assign sat_c = (r > QMAX);
  assign q_c   = sat_c ? {OUT_W{1'b1}} : r[OUT_W-1:0];

  // Stage Q
  logic             q_vld;
  logic [OUT_W-1:0] q_data;
  logic             q_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld  <= 1'b0;
      q_data <= '0;
      q_sat  <= 1'b0;
    end else begin
      q_vld  <= in_valid;
      q_data <= q_c;
      q_sat  <= sat_c;
    end
  end

  // FIFO
  logic         full, empty, push, pop, drop;
  logic [OUT_W:0] head;

  assign pop  = !empty && out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push = q_vld && (!full || pop);
  assign drop = q_vld && full && !pop;

  sync_fifo #(.W(OUT_W+1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({q_data, q_sat}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Last popped entry, shown while empty so dout does not wander onto stale slots.
  logic [OUT_W:0] hold;

  always_ff @(posedge clk) begin
    if (rst)      hold <= '0;
    else if (pop) hold <= head;
  end

  assign out_valid          = !empty;
  assign {dout, dout_sat}   = empty ? hold : head;

  // Drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule
